// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Write-back stage: regfile write, CP0 subset, syscall/eret commit.
//            Count/Compare timer present only when CP0_TIMER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
   parameter logic [31:0] EXC_ENTRY = 32'hbfc0_0380,
   parameter int unsigned CNT_DIV   = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ws_allowin,
   input  logic        ms_to_ws_valid,
   input  logic [85:0] ms_to_ws_bus,
   output logic [40:0] ws_to_rf_bus,
   output logic        flush,
   output logic [31:0] flush_pc,
   output logic [9:0]  stall_ws_bus,
   output logic [32:0] forward_ws_bus,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata
);

   localparam logic [7:0] c_CP0_COUNT   = 8'h48;
   localparam logic [7:0] c_CP0_COMPARE = 8'h58;
   localparam logic [7:0] c_CP0_STATUS  = 8'h60;
   localparam logic [7:0] c_CP0_CAUSE   = 8'h68;
   localparam logic [7:0] c_CP0_EPC     = 8'h70;

   logic        r_ws_valid;
   logic [85:0] r_ms_bus;
   logic [85:0] w_bus;
   logic        w_bd, w_exc_sys, w_eret, w_cp0_wen, w_res_from_cp0;
   logic [7:0]  w_cp0_addr;
   logic [3:0]  w_gr_we;
   logic [4:0]  w_dest;
   logic [31:0] w_result, w_pc;
   logic        w_valid, w_sys_commit, w_eret_commit, w_mtc0;
   logic [3:0]  w_rf_we;
   logic [31:0] w_rf_wdata, w_cp0_rdata;

   logic [7:0]  r_status_im;
   logic        r_status_exl, r_status_ie;
   logic        r_cause_bd;
   logic [1:0]  r_cause_ip_sw;
   logic [4:0]  r_cause_exccode;
   logic [31:0] r_epc;
   logic [31:0] w_count, w_compare;
   logic        w_ti;

   // Every output is derived from the bus view below, so zeroing it covers reset.
   assign w_bus = reset ? '0 : r_ms_bus;
   assign {w_bd, w_exc_sys, w_eret, w_cp0_wen, w_res_from_cp0, w_cp0_addr,
           w_gr_we, w_dest, w_result, w_pc} = w_bus;

   assign w_valid       = r_ws_valid & ~reset;
   assign w_sys_commit  = w_valid & w_exc_sys;
   assign w_eret_commit = w_valid & w_eret;
   assign w_mtc0        = w_valid & w_cp0_wen & ~w_exc_sys;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ws_valid <= 1'b0;
         r_ms_bus   <= '0;
      end else begin
         r_ws_valid <= ms_to_ws_valid & ~flush;
         if (ms_to_ws_valid) r_ms_bus <= ms_to_ws_bus;
      end
   end

   assign w_rf_we    = w_gr_we & {4{w_valid & ~w_exc_sys}};
   assign w_rf_wdata = w_res_from_cp0 ? w_cp0_rdata : w_result;

   assign ws_allowin        = 1'b1;
   assign ws_to_rf_bus      = {w_rf_we, w_dest, w_rf_wdata};
   assign flush             = w_sys_commit | w_eret_commit;
   assign flush_pc          = (reset | w_exc_sys) ? EXC_ENTRY : r_epc;
   assign stall_ws_bus      = {w_valid & (|w_gr_we), {4{w_valid}} & w_gr_we, w_dest};
   assign forward_ws_bus    = {w_valid, w_rf_wdata};
   assign debug_wb_pc       = w_pc;
   assign debug_wb_rf_wen   = w_rf_we;
   assign debug_wb_rf_wnum  = w_dest;
   assign debug_wb_rf_wdata = w_rf_wdata;

   always_comb begin
      w_cp0_rdata = '0;
      case (w_cp0_addr)
         c_CP0_COUNT:   w_cp0_rdata = w_count;
         c_CP0_COMPARE: w_cp0_rdata = w_compare;
         c_CP0_STATUS:  w_cp0_rdata = {9'd0, 1'b1, 6'd0, r_status_im, 6'd0,
                                       r_status_exl, r_status_ie};
         c_CP0_CAUSE:   w_cp0_rdata = {r_cause_bd, w_ti, 14'd0, w_ti, 5'd0,
                                       r_cause_ip_sw, 1'b0, r_cause_exccode, 2'b00};
         c_CP0_EPC:     w_cp0_rdata = r_epc;
         default:       w_cp0_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_status_im     <= '0;
         r_status_exl    <= 1'b0;
         r_status_ie     <= 1'b0;
         r_cause_bd      <= 1'b0;
         r_cause_ip_sw   <= '0;
         r_cause_exccode <= '0;
         r_epc           <= '0;
      end else begin
         if (w_mtc0 && w_cp0_addr == c_CP0_STATUS) begin
            r_status_im  <= w_result[15:8];
            r_status_exl <= w_result[1];
            r_status_ie  <= w_result[0];
         end
         if (w_mtc0 && w_cp0_addr == c_CP0_CAUSE) r_cause_ip_sw <= w_result[9:8];
         if (w_mtc0 && w_cp0_addr == c_CP0_EPC)   r_epc         <= w_result;
         if (w_sys_commit) begin
            r_cause_exccode <= 5'h08;
            r_status_exl    <= 1'b1;
            // A nested exception keeps the EPC/BD of the outer one.
            if (!r_status_exl) begin
               r_epc      <= w_bd ? (w_pc - 32'd4) : w_pc;
               r_cause_bd <= w_bd;
            end
         end else if (w_eret_commit) begin
            r_status_exl <= 1'b0;
         end
      end
   end

`ifdef CP0_TIMER_EN
   localparam int unsigned c_PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
   localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(CNT_DIV - 1);

   logic [c_PW-1:0] r_presc;
   logic [31:0]     r_count, r_compare, w_count_nxt;
   logic            r_ti, w_tick, w_wr_count, w_wr_compare;

   assign w_tick       = (r_presc == c_PRESC_MAX);
   assign w_wr_count   = w_mtc0 & (w_cp0_addr == c_CP0_COUNT);
   assign w_wr_compare = w_mtc0 & (w_cp0_addr == c_CP0_COMPARE);

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_count)  w_count_nxt = w_result;
      else if (w_tick) w_count_nxt = r_count + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc   <= '0;
         r_count   <= '0;
         r_compare <= '0;
         r_ti      <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_presc <= (w_wr_count || w_tick) ? '0 : r_presc + c_PW'(1);
         // The match is taken on the post-update Count; a Compare write wins.
         if (w_wr_compare) begin
            r_compare <= w_result;
            r_ti      <= 1'b0;
         end else if (w_count_nxt == r_compare) begin
            r_ti <= 1'b1;
         end
      end
   end

   assign w_count   = r_count;
   assign w_compare = r_compare;
   assign w_ti      = r_ti;
`else
   assign w_count   = '0;
   assign w_compare = '0;
   assign w_ti      = 1'b0;
`endif

endmodule
`default_nettype wire
